// File: rtl/ram_resp_pkg.sv
// Shared bus widths and drain-FSM state encodings for the ram_resp store-buffered RAM.
package ram_resp_pkg;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;

  typedef enum logic {
    RESP_IDLE = 1'b0,
    RESP_BUSY = 1'b1
  } resp_state_e;

endpackage

// File: rtl/ram_resp_store_fifo.sv
// store_fifo: in-order store buffer for ram_resp. Entry views are age-ordered:
// index 0 is the head (oldest), index DEPTH-1 the youngest possible slot.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 10,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [IW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       ent_vld_o,
  output logic [DEPTH*IW-1:0]    ent_addr_o,
  output logic [DEPTH*DW-1:0]    ent_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          acc;
  logic          rel;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full buffer refuses the push even if the head pops this edge.
  assign acc = push_i && !full_o;
  assign rel = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (acc) wptr_d = wptr_q + 1'b1;
    if (rel) rptr_d = rptr_q + 1'b1;
    if (acc && !rel)      count_d = count_q + 1'b1;
    else if (rel && !acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      addr_q[wptr_q] <= push_addr_i;
      data_q[wptr_q] <= push_data_i;
    end
  end

  always_comb begin
    ent_vld_o  = '0;
    ent_addr_o = '0;
    ent_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_vld_o[k]           = (CW'(k) < count_q);
      ent_addr_o[k*IW +: IW] = addr_q[rptr_q + PW'(k)];
      ent_data_o[k*DW +: DW] = data_q[rptr_q + PW'(k)];
    end
  end

endmodule

// File: rtl/ram_resp.sv
// ram_resp: word RAM behind a store buffer drained by a fixed-latency FSM.
// Optional macro RAM_RESP_FWD_EN: forward buffered stores to loads instead of stalling.
module ram_resp
  import ram_resp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WRITE_LAT = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ramwe,
  input  logic [DataAddrBus-1:0] ramwaddr,
  input  logic [DataBus-1:0]     ramwdata,
  input  logic                   ramre,
  input  logic [DataAddrBus-1:0] ramraddr,
  output logic [DataBus-1:0]     ramdata,
  output logic                   stallreq
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
  localparam logic [LW-1:0] LAT_RELOAD = LW'(WRITE_LAT - 1);

  logic [IW-1:0]         widx;
  logic [IW-1:0]         ridx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH*IW-1:0]   ent_addr;
  logic [DEPTH*DataBus-1:0] ent_data;
  logic [IW-1:0]         head_idx;
  logic [DataBus-1:0]    head_data;

  resp_state_e           state_q, state_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  pop;
  logic                  mem_we;
  logic                  buf_hit;
  logic                  hazard;
  logic [DataBus-1:0]    rd_word;
  logic [DataBus-1:0]    mem_q [MEM_WORDS];

  assign widx = ramwaddr[IW+1:2];
  assign ridx = ramraddr[IW+1:2];

  logic unused_addr;
  assign unused_addr = ^{ramwaddr[DataAddrBus-1:IW+2], ramwaddr[1:0],
                         ramraddr[DataAddrBus-1:IW+2], ramraddr[1:0]};

  store_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .DW    (DataBus)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ramwe),
    .push_addr_i (widx),
    .push_data_i (ramwdata),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt),
    .ent_vld_o   (ent_vld),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data)
  );

  assign head_idx  = ent_addr[IW-1:0];
  assign head_data = ent_data[DataBus-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESP_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    case (state_q)
      RESP_IDLE: begin
        if (!fifo_empty) begin
          state_d = RESP_BUSY;
          lat_d   = LAT_RELOAD;
        end
      end
      RESP_BUSY: begin
        if (lat_q == '0) begin
          pop = 1'b1;
          if (fifo_cnt > CW'(1)) lat_d   = LAT_RELOAD;
          else                   state_d = RESP_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = RESP_IDLE;
    endcase
  end

  // Reset on the commit edge aborts the write, leaving the word untouched.
  assign mem_we = pop && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[head_idx] <= head_data;
  end

`ifdef RAM_RESP_FWD_EN
  logic [DataBus-1:0] fwd_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    buf_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && (ent_addr[k*IW +: IW] == ridx)) begin
        buf_hit  = 1'b1;
        fwd_data = ent_data[k*DataBus +: DataBus];
      end
    end
  end

  assign hazard  = 1'b0;
  assign rd_word = buf_hit ? fwd_data : mem_q[ridx];
`else
  logic unused_fwd;
  assign unused_fwd = ^ent_data;

  always_comb begin
    buf_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && (ent_addr[k*IW +: IW] == ridx)) buf_hit = 1'b1;
    end
  end

  assign hazard  = ramre && buf_hit;
  assign rd_word = mem_q[ridx];
`endif

  assign ramdata  = (ramre && !rst) ? rd_word : '0;
  assign stallreq = !rst && (fifo_full || hazard);

endmodule

// File: tb/tb_ram_resp.sv
// Directed bench for ram_resp: one DUT at WRITE_LAT=2, one at WRITE_LAT=8 for overflow cases.
module tb_ram_resp;
  import ram_resp_pkg::*;

`ifdef RAM_RESP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we, a_re, a_stall;
  logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
  logic        b_we, b_re, b_stall;
  logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_resp #(.DEPTH(4), .WRITE_LAT(2), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .ramwe(a_we), .ramwaddr(a_waddr), .ramwdata(a_wdata),
    .ramre(a_re), .ramraddr(a_raddr), .ramdata(a_rdata), .stallreq(a_stall)
  );

  ram_resp #(.DEPTH(4), .WRITE_LAT(8), .MEM_WORDS(1024)) dut8 (
    .clk(clk), .rst(rst), .ramwe(b_we), .ramwaddr(b_waddr), .ramwdata(b_wdata),
    .ramre(b_re), .ramraddr(b_raddr), .ramdata(b_rdata), .stallreq(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1'b1;
    a_we = 1'b0; a_re = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_we = 1'b0; b_re = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    tick(); tick();

    // Reset state and empty load
    a_re = 1'b1; a_raddr = 32'h40; #1;
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_stall", a_stall, 32'h0);
    rst = 1'b0; #1;
    chk("rst_count", dut.u_fifo.count_o, 32'd0);
    chk("rst_state", dut.state_q, RESP_IDLE);
    chk("load_empty", a_rdata, 32'h0);
    chk("stall_empty", a_stall, 32'h0);

    // Store with a same-cycle load to the same word: no forwarding
    a_we = 1'b1; a_waddr = 32'h40; a_wdata = 32'hDEADBEEF; #1;
    chk("same_cyc_data", a_rdata, 32'h0);
    chk("same_cyc_stall", a_stall, 32'h0);
    tick();
    a_we = 1'b0; #1;
    chk("count_one", dut.u_fifo.count_o, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("raw_data_c%0d", c), a_rdata, FWD ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("raw_stall_c%0d", c), a_stall, FWD ? 32'h0 : 32'h1);
      tick();
    end
    chk("raw_data_done", a_rdata, 32'hDEADBEEF);
    chk("raw_stall_done", a_stall, 32'h0);
    chk("raw_count_done", dut.u_fifo.count_o, 32'd0);
    a_raddr = 32'h8000_0043; #1;
    chk("addr_alias", a_rdata, 32'hDEADBEEF);
    a_re = 1'b0; #1;
    chk("re_low_zero", a_rdata, 32'h0);

    // Two stores to the same word: youngest wins
    a_we = 1'b1; a_waddr = 32'h10; a_wdata = 32'd1; tick();
    a_wdata = 32'd2; tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr = 32'h10; #1;
    chk("youngest_data", a_rdata, FWD ? 32'd2 : 32'd0);
    chk("youngest_stall", a_stall, FWD ? 32'h0 : 32'h1);
    repeat (8) tick();
    chk("youngest_array", a_rdata, 32'd2);
    chk("youngest_stall_done", a_stall, 32'h0);

    // Reset mid-BUSY aborts the pending write
    a_re = 1'b0; a_we = 1'b1; a_waddr = 32'h80; a_wdata = 32'h11; tick();
    a_we = 1'b0; repeat (6) tick();
    a_re = 1'b1; a_raddr = 32'h80; #1;
    chk("pre_rst_word", a_rdata, 32'h11);
    a_re = 1'b0; a_we = 1'b1; a_wdata = 32'h55; tick();
    a_we = 1'b0; tick();
    chk("busy_before_rst", dut.state_q, RESP_BUSY);
    rst = 1'b1; a_re = 1'b1; #1;
    chk("rst_mid_rdata", a_rdata, 32'h0);
    chk("rst_mid_stall", a_stall, 32'h0);
    tick();
    rst = 1'b0; #1;
    chk("rst_mid_count", dut.u_fifo.count_o, 32'd0);
    chk("rst_mid_state", dut.state_q, RESP_IDLE);
    chk("rst_mid_lat", dut.lat_q, 32'd0);
    repeat (6) tick();
    chk("rst_kept_word", a_rdata, 32'h11);
    chk("rst_kept_stall", a_stall, 32'h0);
    a_re = 1'b0;

    // Overflow on the WRITE_LAT=8 instance; 0x110 preloaded so the dropped store is visible
    b_we = 1'b1; b_waddr = 32'h110; b_wdata = 32'h77; tick();
    b_we = 1'b0; repeat (12) tick();
    chk("b_preload_count", dut8.u_fifo.count_o, 32'd0);
    for (int k = 0; k < 5; k++) begin
      b_we = 1'b1; b_waddr = 32'h100 + 32'(4 * k); b_wdata = 32'hA0 + 32'(k); #1;
      if (k == 4) begin
        chk("b_full_stall", b_stall, 32'h1);
        chk("b_full_count", dut8.u_fifo.count_o, 32'd4);
      end
      tick();
    end
    b_we = 1'b0; #1;
    chk("b_fifth_dropped", dut8.u_fifo.count_o, 32'd4);
    repeat (4) tick();

    // Push coincident with the pop at count==DEPTH
    b_we = 1'b1; b_waddr = 32'h120; b_wdata = 32'h99; #1;
    chk("b_pop_edge_lat", dut8.lat_q, 32'd0);
    chk("b_pop_edge_count", dut8.u_fifo.count_o, 32'd4);
    chk("b_pop_edge_stall", b_stall, 32'h1);
    tick();
    b_we = 1'b0; #1;
    chk("b_after_pop_count", dut8.u_fifo.count_o, 32'd3);
    chk("b_after_pop_stall", b_stall, 32'h0);

    guard = 0;
    while ((dut8.u_fifo.count_o != 0) && (guard < 100)) begin
      tick();
      guard++;
    end
    chk("b_drain_in_time", 32'(guard < 100), 32'd1);
    b_re = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_raddr = 32'h100 + 32'(4 * k); #1;
      chk($sformatf("b_word%0d", k), b_rdata, 32'hA0 + 32'(k));
    end
    b_raddr = 32'h110; #1;
    chk("b_dropped_word", b_rdata, 32'h77);
    chk("b_final_stall", b_stall, 32'h0);
    b_re = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
